dual_port_blockram: RTL
=======================

# dual_port_blockram

Parametrised true dual-port block RAM with per-byte write masks, a configurable read pipeline and a defined cross-port collision policy. It generalises the single-port blockram for structures that need concurrent fill and lookup on one array, such as cache data/tag arrays and the branch-predictor tables. An optional clear engine zeroes the whole array after reset.

## Interface
- SINGLE_ENTRY_WIDTH_IN_BITS, 64, entry width; must be a multiple of `BYTE_LEN_IN_BITS
- NUM_SET, 64, number of entries
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width
- WRITE_MASK_LEN, SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS, byte-enable width
- READ_LATENCY, 1, clock edges from access to data; legal range 1..4
- WRITE_MODE, 0, same-port read-during-write: 0 returns old data (read-first), 1 returns merged new data (write-first)

Ports:
- clk_in  input  1  clock, all state on rising edge
- reset_in  input  1  reset, asynchronous and active-low
- access_en_a_in / access_en_b_in  input  1  port access request
- write_en_a_in / write_en_b_in  input  WRITE_MASK_LEN  byte write enables; all zero means read only
- access_set_addr_a_in / access_set_addr_b_in  input  SET_PTR_WIDTH_IN_BITS  entry index
- write_entry_a_in / write_entry_b_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  write data
- read_entry_a_out / read_entry_b_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  read data
- read_valid_a_out / read_valid_b_out  output  1  one-cycle pulse marking valid read data
- busy_out  output  1  clear engine active; accesses are ignored

## Operation
- An access is accepted on a rising edge when access_en_x_in=1 and busy_out=0. Every accepted access, read or write, produces a read result.
- Write: byte i of the entry is updated iff write_en_x_in[i]=1. Masked-off bytes are unchanged.
- Read data source:
  - WRITE_MODE=0: contents before the same-edge write.
  - WRITE_MODE=1: contents after that port's own write.
- Cross-port, same set, same edge:
  - Both writing: for bytes enabled on both ports, port A wins. Bytes enabled on one port take that port's data.
  - One port reading while the other writes: the reader always gets the old data, whatever WRITE_MODE is.
- read_entry_x_out holds its last value until the next valid result.
- An accepted access while busy_out=1 is dropped: no write, no read_valid.
- Reset: read_entry_a/b_out=0, read_valid_a/b_out=0, busy_out=0 (1 if the clear feature is enabled). Read pipelines are flushed. Array contents are not reset by the reset pin.

## Timing
- An access accepted at edge N gives read_valid_x_out=1 and data from edge N+READ_LATENCY-1 until edge N+READ_LATENCY.
- Back-to-back accesses are fully pipelined: one result per port per cycle, returned in order.
- Each port's pipeline stage count equals READ_LATENCY. Stages 2..READ_LATENCY are plain registers carrying valid and data.
- Reset asserted mid-pipeline drops all in-flight results. No read_valid appears after reset deassertion for those results.

## Configuration
- BLOCKRAM_CLEAR_ON_RESET_EN defined:
  - A clear FSM with states IDLE and CLEAR.
  - Reset forces CLEAR with pointer 0 and busy_out=1.
  - After reset release, one entry is written to zero per cycle, NUM_SET cycles in total.
  - After writing entry NUM_SET-1, the FSM moves to IDLE and busy_out=0 from the following cycle.
  - Reset during CLEAR restarts from pointer 0.
- Not defined:
  - No FSM; busy_out is tied to 0.
  - Contents are undefined (x in simulation) until written.

## Test plan
- Port A writes 0xFFFFFFFF00000000 to set 63 with mask 0xFF; port A reads set 63 -> after READ_LATENCY, read_entry_a_out=0xFFFFFFFF00000000 with a single read_valid_a_out pulse.
- Port A writes 0 to set 62 with mask 0xFF, then writes all-ones with mask 0xCC; port B reads set 62 -> 0xFFFF0000FFFF0000.
- Same edge: A writes 0x1111111111111111 with mask 0x0F and B writes 0x2222222222222222 with mask 0xFF, both to set 5; A then reads set 5 -> 0x2222222211111111.
- Same edge: B writes 0xAAAA… to set 7, which held 0x5555…, while A reads set 7 -> A returns 0x5555…. With WRITE_MODE=1, B's own read data is 0xAAAA….
- READ_LATENCY=3: 8 back-to-back reads of sets 0..7 on both ports -> 8 consecutive valid pulses per port, first on the 3rd edge, in order. Reset asserted after the 4th access -> no further valid pulses.
- With BLOCKRAM_CLEAR_ON_RESET_EN and NUM_SET=64: busy_out=1 for exactly 64 cycles after reset release; an access during busy gives no read_valid; a read of every set afterwards returns 0.

Source files
------------

// File: rtl/dual_port_blockram.sv
// dual_port_blockram
//   True dual-port RAM with per-byte write enables and a READ_LATENCY-deep
//   read pipeline on each port. Every accepted access, whether a read or a
//   write, returns one read result. When both ports write the same set on
//   the same edge, port A wins the bytes that both ports enable.
//
//   Optional feature macro: BLOCKRAM_CLEAR_ON_RESET_EN. When it is defined,
//   a clear engine zeroes one entry per cycle after reset and holds busy_out
//   high until the whole array is zero.
//
// Ports
//   clk_in, reset_in           clock (rising edge) / async active-low reset
//   access_en_{a,b}_in         access request
//   write_en_{a,b}_in          byte write enables (all zero = read only)
//   access_set_addr_{a,b}_in   entry index
//   write_entry_{a,b}_in       write data
//   read_entry_{a,b}_out       read data, held until the next valid result
//   read_valid_{a,b}_out       one-cycle pulse per result
//   busy_out                   clear engine active; accesses are dropped

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module dual_port_blockram #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int READ_LATENCY               = 1,   // 1..4
    parameter int WRITE_MODE                 = 0    // 0 read-first, 1 write-first
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  access_en_a_in,
    input  logic                                  access_en_b_in,
    input  logic [WRITE_MASK_LEN-1:0]             write_en_a_in,
    input  logic [WRITE_MASK_LEN-1:0]             write_en_b_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      access_set_addr_a_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      access_set_addr_b_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_a_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_b_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_a_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_b_out,
    output logic                                  read_valid_a_out,
    output logic                                  read_valid_b_out,
    output logic                                  busy_out
);

    localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int BL = `BYTE_LEN_IN_BITS;

    logic [W-1:0] mem [NUM_SET];

    // Byte-wise merge of write data into an existing entry.
    function automatic logic [W-1:0] merge(input logic [W-1:0] old,
                                           input logic [WRITE_MASK_LEN-1:0] wen,
                                           input logic [W-1:0] wdata);
        logic [W-1:0] r;
        r = old;
        for (int i = 0; i < WRITE_MASK_LEN; i++)
            if (wen[i]) r[i*BL +: BL] = wdata[i*BL +: BL];
        return r;
    endfunction

    logic         acc_a, acc_b, wr_a, wr_b, same_set;
    logic [W-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

    assign acc_a    = access_en_a_in && !busy_out;
    assign acc_b    = access_en_b_in && !busy_out;
    assign wr_a     = acc_a && |write_en_a_in;
    assign wr_b     = acc_b && |write_en_b_in;
    assign same_set = access_set_addr_a_in == access_set_addr_b_in;
    assign old_a    = mem[access_set_addr_a_in];
    assign old_b    = mem[access_set_addr_b_in];

    // B's entry only carries B's bytes. A's entry layers A's bytes on top of
    // B's bytes when both ports write the same set, so that A wins on
    // overlapping bytes and B keeps the bytes that only B enables. A's write
    // happens last, so it is the one that lands in the array.
    assign new_b = merge(old_b, write_en_b_in, write_entry_b_in);
    assign new_a = merge((wr_b && same_set) ? new_b : old_a,
                         write_en_a_in, write_entry_a_in);

    // Write-first shows only the port's own write. A cross-port write never
    // appears in the other port's read data.
    assign rd_a = (WRITE_MODE == 1) ? merge(old_a, write_en_a_in, write_entry_a_in) : old_a;
    assign rd_b = (WRITE_MODE == 1) ? new_b : old_b;

`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
    typedef enum logic {IDLE, CLEAR} clr_state_t;
    clr_state_t                       state, state_nxt;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] clr_ptr, clr_ptr_nxt;
    logic                             clr_we;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we      = 1'b0;
        busy_out    = 1'b0;
        case (state)
            CLEAR: begin
                busy_out    = 1'b1;
                clr_we      = 1'b1;
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) begin
                    state_nxt   = IDLE;
                    clr_ptr_nxt = '0;
                end
            end
            default: ;
        endcase
    end
`else
    assign busy_out = 1'b0;
`endif

    // Array storage has no reset. Port A is written after port B, so on a
    // same-set double write A's merged entry is the final value.
    always_ff @(posedge clk_in) begin
`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
        if (clr_we) mem[clr_ptr] <= '0;
`endif
        if (wr_b) mem[access_set_addr_b_in] <= new_b;
        if (wr_a) mem[access_set_addr_a_in] <= new_a;
    end

    // Read pipelines. Stage 0 samples the array. The later stages are plain
    // registers. A stage's data register only loads together with a valid
    // result, so the last stage holds its data between results.
    logic [READ_LATENCY-1:0]        vld_pipe_a, vld_pipe_b;
    logic [READ_LATENCY-1:0][W-1:0] dat_pipe_a, dat_pipe_b;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            vld_pipe_a <= '0;
            vld_pipe_b <= '0;
            dat_pipe_a <= '0;
            dat_pipe_b <= '0;
        end else begin
            vld_pipe_a[0] <= acc_a;
            vld_pipe_b[0] <= acc_b;
            if (acc_a) dat_pipe_a[0] <= rd_a;
            if (acc_b) dat_pipe_b[0] <= rd_b;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_a[i] <= vld_pipe_a[i-1];
                vld_pipe_b[i] <= vld_pipe_b[i-1];
                if (vld_pipe_a[i-1]) dat_pipe_a[i] <= dat_pipe_a[i-1];
                if (vld_pipe_b[i-1]) dat_pipe_b[i] <= dat_pipe_b[i-1];
            end
        end
    end

    assign read_valid_a_out = vld_pipe_a[READ_LATENCY-1];
    assign read_valid_b_out = vld_pipe_b[READ_LATENCY-1];
    assign read_entry_a_out = dat_pipe_a[READ_LATENCY-1];
    assign read_entry_b_out = dat_pipe_b[READ_LATENCY-1];

endmodule
